// File: rtl/wb_retire.sv
// rtl/wb_retire.sv - RV32I write-back/retire stage with load alignment, retire counter and trace FIFO
module wb_retire #(
   parameter int TRACE_DEPTH = 4,
   parameter int CNT_WIDTH   = 64
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 STALL,
   input  logic                 FLUSH,
   input  logic [31:0]          M_PC,
   input  logic [31:0]          M_INST,
   input  logic                 M_VALID,
   input  logic [4:0]           M_REG_D,
   input  logic [31:0]          M_REG_D_V,
   input  logic [31:0]          M_LOAD_ADDR,
   input  logic [31:0]          M_LOAD_DATA,
   output logic [31:0]          W_PC,
   output logic [31:0]          W_INST,
   output logic                 W_VALID,
   output logic [4:0]           W_REG_D,
   output logic [31:0]          W_REG_D_V,
   output logic                 W_REG_WE,
   output logic [CNT_WIDTH-1:0] INSTRET,
   output logic                 TRACE_VALID,
   output logic [31:0]          TRACE_PC,
   output logic [31:0]          TRACE_INST,
   input  logic                 TRACE_READY,
   output logic                 TRACE_OVF
);

   localparam int AW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
   localparam logic [AW:0] DEPTH_C = TRACE_DEPTH[AW:0];

   // Only the byte lane of the load address matters; upper bits are unused.
   logic unused_addr;
   assign unused_addr = &{1'b0, M_LOAD_ADDR[31:2]};

   logic        is_load;
   logic [2:0]  funct3;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [31:0] m_result;

   assign is_load = (M_INST[6:0] == 7'b0000011);
   assign funct3  = M_INST[14:12];

   // Select byte/halfword lane from the raw word and extend per load type.
   always_comb begin
      lane_byte = M_LOAD_DATA[7:0];
      case (M_LOAD_ADDR[1:0])
         2'd0: lane_byte = M_LOAD_DATA[7:0];
         2'd1: lane_byte = M_LOAD_DATA[15:8];
         2'd2: lane_byte = M_LOAD_DATA[23:16];
         2'd3: lane_byte = M_LOAD_DATA[31:24];
         default: lane_byte = M_LOAD_DATA[7:0];
      endcase
      lane_half = M_LOAD_ADDR[1] ? M_LOAD_DATA[31:16] : M_LOAD_DATA[15:0];
      m_result  = M_REG_D_V;
      if (is_load) begin
         case (funct3)
            3'b000:  m_result = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  m_result = {24'd0, lane_byte};
            3'b001:  m_result = {{16{lane_half[15]}}, lane_half};
            3'b101:  m_result = {16'd0, lane_half};
            default: m_result = M_LOAD_DATA;
         endcase
      end
   end

   // A retire is a valid entry actually captured into the stage this edge.
   logic retire;
   assign retire = M_VALID && !RST && !STALL && !FLUSH;

   // Stage register: reset > stall (hold) > flush (bubble) > capture.
   always_ff @(posedge CLK) begin
      if (RST) begin
         W_PC      <= '0;
         W_INST    <= '0;
         W_VALID   <= 1'b0;
         W_REG_D   <= '0;
         W_REG_D_V <= '0;
      end else if (STALL) begin
         W_PC      <= W_PC;
      end else if (FLUSH) begin
         W_PC      <= '0;
         W_INST    <= '0;
         W_VALID   <= 1'b0;
         W_REG_D   <= '0;
         W_REG_D_V <= '0;
      end else begin
         W_PC      <= M_PC;
         W_INST    <= M_INST;
         W_VALID   <= M_VALID;
         W_REG_D   <= M_REG_D;
         W_REG_D_V <= m_result;
      end
   end

   // x0 is never written.
   assign W_REG_WE = W_VALID && (W_REG_D != 5'd0);

   // Retired-instruction counter, wraps naturally at its width.
   always_ff @(posedge CLK) begin
      if (RST) begin
         INSTRET <= '0;
      end else if (retire) begin
         INSTRET <= INSTRET + CNT_WIDTH'(1);
      end
   end

   logic [31:0] pc_mem   [TRACE_DEPTH];
   logic [31:0] inst_mem [TRACE_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          fifo_full;
   logic          fifo_pop;
   logic          fifo_push;
   logic          fifo_drop;

   assign fifo_full   = (count == DEPTH_C);
   assign TRACE_VALID = (count != '0);
   assign fifo_pop    = TRACE_VALID && TRACE_READY;
   // A pop on the same edge frees the slot, so a full FIFO still accepts.
   assign fifo_push   = retire && (!fifo_full || fifo_pop);
   assign fifo_drop   = retire && fifo_full && !fifo_pop;
   assign TRACE_PC    = pc_mem[rd_ptr];
   assign TRACE_INST  = inst_mem[rd_ptr];

   // Trace FIFO storage, pointers, occupancy and sticky overflow flag.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         TRACE_OVF <= 1'b0;
         for (int i = 0; i < TRACE_DEPTH; i++) begin
            pc_mem[i]   <= '0;
            inst_mem[i] <= '0;
         end
      end else begin
         if (fifo_push) begin
            pc_mem[wr_ptr]   <= M_PC;
            inst_mem[wr_ptr] <= M_INST;
            wr_ptr           <= wr_ptr + AW'(1);
         end
         if (fifo_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (fifo_push && !fifo_pop) begin
            count <= count + (AW+1)'(1);
         end else if (!fifo_push && fifo_pop) begin
            count <= count - (AW+1)'(1);
         end
         if (fifo_drop) begin
            TRACE_OVF <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_wb_retire.sv
// tb/tb_wb_retire.sv - self-checking bench for wb_retire
module tb_wb_retire;

   logic        CLK;
   logic        RST;
   logic        STALL;
   logic        FLUSH;
   logic [31:0] M_PC;
   logic [31:0] M_INST;
   logic        M_VALID;
   logic [4:0]  M_REG_D;
   logic [31:0] M_REG_D_V;
   logic [31:0] M_LOAD_ADDR;
   logic [31:0] M_LOAD_DATA;
   logic        TRACE_READY;

   logic [31:0] W_PC, W_INST, W_REG_D_V, TRACE_PC, TRACE_INST;
   logic        W_VALID, W_REG_WE, TRACE_VALID, TRACE_OVF;
   logic [4:0]  W_REG_D;
   logic [63:0] INSTRET;

   logic [31:0] w_pc4, w_inst4, w_reg_d_v4, trace_pc4, trace_inst4;
   logic        w_valid4, w_reg_we4, trace_valid4, trace_ovf4;
   logic [4:0]  w_reg_d4;
   logic [3:0]  instret4;

   wb_retire #(.TRACE_DEPTH(4), .CNT_WIDTH(64)) u_dut (
      .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH),
      .M_PC(M_PC), .M_INST(M_INST), .M_VALID(M_VALID), .M_REG_D(M_REG_D),
      .M_REG_D_V(M_REG_D_V), .M_LOAD_ADDR(M_LOAD_ADDR), .M_LOAD_DATA(M_LOAD_DATA),
      .W_PC(W_PC), .W_INST(W_INST), .W_VALID(W_VALID), .W_REG_D(W_REG_D),
      .W_REG_D_V(W_REG_D_V), .W_REG_WE(W_REG_WE), .INSTRET(INSTRET),
      .TRACE_VALID(TRACE_VALID), .TRACE_PC(TRACE_PC), .TRACE_INST(TRACE_INST),
      .TRACE_READY(TRACE_READY), .TRACE_OVF(TRACE_OVF)
   );

   wb_retire #(.TRACE_DEPTH(4), .CNT_WIDTH(4)) u_dut4 (
      .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH),
      .M_PC(M_PC), .M_INST(M_INST), .M_VALID(M_VALID), .M_REG_D(M_REG_D),
      .M_REG_D_V(M_REG_D_V), .M_LOAD_ADDR(M_LOAD_ADDR), .M_LOAD_DATA(M_LOAD_DATA),
      .W_PC(w_pc4), .W_INST(w_inst4), .W_VALID(w_valid4), .W_REG_D(w_reg_d4),
      .W_REG_D_V(w_reg_d_v4), .W_REG_WE(w_reg_we4), .INSTRET(instret4),
      .TRACE_VALID(trace_valid4), .TRACE_PC(trace_pc4), .TRACE_INST(trace_inst4),
      .TRACE_READY(TRACE_READY), .TRACE_OVF(trace_ovf4)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic retire_one(input logic [31:0] pc);
      M_VALID = 1'b1;
      M_PC    = pc;
      M_INST  = 32'h00000013;
      M_REG_D = 5'd1;
      step();
      M_VALID = 1'b0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      step();
      RST = 1'b0;
   endtask

   typedef struct {
      logic        stall;
      logic        flush;
      logic        valid;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [4:0]  rd;
      logic [31:0] rdv;
      logic [31:0] addr;
      logic [31:0] data;
      logic        e_valid;
      logic [31:0] e_val;
      logic        e_we;
   } vec_t;

   function automatic vec_t mk(input logic flush, input logic valid, input logic [31:0] pc,
                               input logic [31:0] inst, input logic [4:0] rd,
                               input logic [31:0] rdv, input logic [31:0] addr,
                               input logic e_valid, input logic [31:0] e_val, input logic e_we);
      vec_t v;
      v.stall = 1'b0; v.flush = flush; v.valid = valid; v.pc = pc; v.inst = inst;
      v.rd = rd; v.rdv = rdv; v.addr = addr; v.data = 32'h8091A2F3;
      v.e_valid = e_valid; v.e_val = e_val; v.e_we = e_we;
      return v;
   endfunction

   vec_t vecs[11];
   logic [63:0] exp_cnt;
   logic [31:0] exp_pc;
   logic [31:0] exp_q[$];

   initial begin
      vecs[0]  = mk(0, 1, 32'h104, 32'h00000003, 5'd6, 32'h11111111, 32'h1000, 1, 32'hFFFFFFF3, 1); // LB lane0
      vecs[1]  = mk(0, 1, 32'h108, 32'h00004003, 5'd6, 32'h11111111, 32'h1002, 1, 32'h00000091, 1); // LBU lane2
      vecs[2]  = mk(0, 1, 32'h10C, 32'h00001003, 5'd7, 32'h11111111, 32'h1003, 1, 32'hFFFF8091, 1); // LH hi
      vecs[3]  = mk(0, 1, 32'h110, 32'h00005003, 5'd7, 32'h11111111, 32'h1001, 1, 32'h0000A2F3, 1); // LHU lo
      vecs[4]  = mk(0, 1, 32'h114, 32'h00002003, 5'd8, 32'h11111111, 32'h1000, 1, 32'h8091A2F3, 1); // LW
      vecs[5]  = mk(0, 1, 32'h118, 32'h00000003, 5'd8, 32'h11111111, 32'h1001, 1, 32'hFFFFFFA2, 1); // LB lane1
      vecs[6]  = mk(0, 1, 32'h11C, 32'h00004003, 5'd9, 32'h11111111, 32'h1003, 1, 32'h00000080, 1); // LBU lane3
      vecs[7]  = mk(0, 1, 32'h120, 32'h00003003, 5'd9, 32'h11111111, 32'h1002, 1, 32'h8091A2F3, 1); // funct3 011
      vecs[8]  = mk(0, 1, 32'h124, 32'h00000013, 5'd0, 32'hCAFEF00D, 32'h1000, 1, 32'hCAFEF00D, 0); // x0
      vecs[9]  = mk(0, 0, 32'h128, 32'h00000013, 5'd7, 32'h0BADF00D, 32'h1000, 0, 32'h0BADF00D, 0); // invalid
      vecs[10] = mk(1, 1, 32'h12C, 32'h00000013, 5'd7, 32'h0BADF00D, 32'h1000, 0, 32'h00000000, 0); // flush

      RST = 1'b0; STALL = 1'b0; FLUSH = 1'b0; M_PC = '0; M_INST = '0; M_VALID = 1'b0;
      M_REG_D = '0; M_REG_D_V = '0; M_LOAD_ADDR = '0; M_LOAD_DATA = '0; TRACE_READY = 1'b0;
      exp_cnt = '0;

      // Reset state
      RST = 1'b1;
      step();
      step();
      RST = 1'b0;
      chk("rst_w_pc", W_PC, 0);
      chk("rst_w_valid", W_VALID, 0);
      chk("rst_w_we", W_REG_WE, 0);
      chk("rst_w_val", W_REG_D_V, 0);
      chk("rst_instret", INSTRET, 0);
      chk("rst_trace_valid", TRACE_VALID, 0);
      chk("rst_trace_ovf", TRACE_OVF, 0);
      chk("rst_trace_pc", TRACE_PC, 0);

      // First retire through the pipe
      M_VALID = 1'b1; M_PC = 32'h100; M_INST = 32'h00000013; M_REG_D = 5'd5;
      M_REG_D_V = 32'hDEADBEEF;
      step();
      exp_cnt = 1;
      chk("pipe_w_pc", W_PC, 32'h100);
      chk("pipe_w_val", W_REG_D_V, 32'hDEADBEEF);
      chk("pipe_w_we", W_REG_WE, 1);
      chk("pipe_instret", INSTRET, exp_cnt);
      chk("pipe_trace_valid", TRACE_VALID, 1);
      chk("pipe_trace_pc", TRACE_PC, 32'h100);

      // Table-driven loads and bubbles
      TRACE_READY = 1'b1;
      for (int i = 0; i < 11; i++) begin
         STALL = vecs[i].stall; FLUSH = vecs[i].flush; M_VALID = vecs[i].valid;
         M_PC = vecs[i].pc; M_INST = vecs[i].inst; M_REG_D = vecs[i].rd;
         M_REG_D_V = vecs[i].rdv; M_LOAD_ADDR = vecs[i].addr; M_LOAD_DATA = vecs[i].data;
         step();
         if (vecs[i].valid && !vecs[i].stall && !vecs[i].flush) exp_cnt++;
         exp_pc = vecs[i].flush ? 32'h0 : vecs[i].pc;
         chk($sformatf("v%0d_valid", i), W_VALID, vecs[i].e_valid);
         chk($sformatf("v%0d_val", i), W_REG_D_V, vecs[i].e_val);
         chk($sformatf("v%0d_we", i), W_REG_WE, vecs[i].e_we);
         chk($sformatf("v%0d_pc", i), W_PC, exp_pc);
         chk($sformatf("v%0d_instret", i), INSTRET, exp_cnt);
      end
      FLUSH = 1'b0; M_VALID = 1'b0;
      step();
      chk("tbl_drained", TRACE_VALID, 0);

      // Stall+flush freeze, then flush alone
      TRACE_READY = 1'b0;
      M_VALID = 1'b1; M_PC = 32'h400; M_INST = 32'h00000013; M_REG_D = 5'd3;
      M_REG_D_V = 32'h1234;
      step();
      exp_cnt++;
      STALL = 1'b1; FLUSH = 1'b1; M_PC = 32'h500; M_REG_D_V = 32'h5555;
      step();
      step();
      chk("stall_w_pc", W_PC, 32'h400);
      chk("stall_w_val", W_REG_D_V, 32'h1234);
      chk("stall_w_valid", W_VALID, 1);
      chk("stall_instret", INSTRET, exp_cnt);
      STALL = 1'b0;
      step();
      chk("flush_w_valid", W_VALID, 0);
      chk("flush_w_we", W_REG_WE, 0);
      chk("flush_instret", INSTRET, exp_cnt);
      FLUSH = 1'b0; M_VALID = 1'b0;
      chk("flush_head_pc", TRACE_PC, 32'h400);
      TRACE_READY = 1'b1;
      step();
      chk("flush_no_push", TRACE_VALID, 0);

      // Overflow: five retires into a four-entry FIFO
      do_reset();
      TRACE_READY = 1'b0;
      for (int i = 0; i < 5; i++) retire_one(32'h200 + 32'(4 * i));
      chk("ovf_flag", TRACE_OVF, 1);
      chk("ovf_head", TRACE_PC, 32'h200);
      chk("ovf_instret", INSTRET, 5);
      TRACE_READY = 1'b1;
      retire_one(32'h214);
      exp_q = '{32'h204, 32'h208, 32'h20C, 32'h214};
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("ovf_valid%0d", i), TRACE_VALID, 1);
         chk($sformatf("ovf_order%0d", i), TRACE_PC, exp_q[i]);
         step();
      end
      chk("ovf_empty", TRACE_VALID, 0);
      chk("ovf_sticky", TRACE_OVF, 1);

      // Drain three entries, then reset mid-drain
      do_reset();
      TRACE_READY = 1'b0;
      for (int i = 0; i < 3; i++) retire_one(32'h300 + 32'(4 * i));
      TRACE_READY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("drain_pc%0d", i), TRACE_PC, 32'h300 + 32'(4 * i));
         step();
      end
      chk("drain_empty", TRACE_VALID, 0);
      TRACE_READY = 1'b0;
      for (int i = 0; i < 3; i++) retire_one(32'h600 + 32'(4 * i));
      TRACE_READY = 1'b1;
      step();
      chk("mid_head", TRACE_PC, 32'h604);
      STALL = 1'b1; RST = 1'b1;
      step();
      STALL = 1'b0; RST = 1'b0;
      chk("mid_rst_valid", TRACE_VALID, 0);
      chk("mid_rst_instret", INSTRET, 0);
      chk("mid_rst_ovf", TRACE_OVF, 0);

      // Counter wrap on the 4-bit instance
      for (int i = 0; i < 17; i++) retire_one(32'h700 + 32'(4 * i));
      chk("wrap_instret4", 64'(instret4), 1);
      chk("wrap_instret64", INSTRET, 17);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
